// File: rtl/player1_controller_pkg.sv
// Shared types and constants for the player motion stage: state encoding,
// HID keycodes and the default physics/screen parameters.
package player_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } player_state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;

    localparam int DEF_X_MIN     = 0;
    localparam int DEF_X_MAX     = 639;
    localparam int DEF_Y_MIN     = 0;
    localparam int DEF_Y_MAX     = 479;
    localparam int DEF_P_W       = 32;
    localparam int DEF_P_H       = 64;
    localparam int DEF_X_START   = 100;
    localparam int DEF_WALK_STEP = 2;
    localparam int DEF_JUMP_VEL  = 12;
    localparam int DEF_GRAVITY   = 1;
    localparam int DEF_MAX_FALL  = 12;

    // A key counts as pressed if either HID slot reports it.
    function automatic logic key_pressed(input logic [15:0] kc, input logic [7:0] key);
        return (kc[7:0] == key) || (kc[15:8] == key);
    endfunction

endpackage

// File: rtl/player1_controller_frame_tick_sync.sv
// Brings the frame strobe into the Clk domain and emits a one-cycle tick
// per rising edge of frame_clk.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= frame_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/player1_controller.sv
// Per-frame player motion (walk, jump, gravity) and per-pixel sprite hit test.
// Define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player1_controller
    import player_pkg::*;
#(
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int P_W       = DEF_P_W,
    parameter int P_H       = DEF_P_H,
    parameter int X_START   = DEF_X_START,
    parameter int WALK_STEP = DEF_WALK_STEP,
    parameter int JUMP_VEL  = DEF_JUMP_VEL,
    parameter int GRAVITY   = DEF_GRAVITY,
    parameter int MAX_FALL  = DEF_MAX_FALL
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        is_player1,
    output logic [9:0]  p1x,
    output logic [9:0]  p1y,
    output logic [9:0]  p1_w,
    output logic [9:0]  p1_h,
    output logic [12:0] spr_addr,
    output logic [1:0]  p1_state,
    output logic        facing
);

    typedef logic signed [10:0] pos_t;

    localparam int GROUND_Y = Y_MAX - P_H + 1;
    localparam int XR       = X_MAX - P_W + 1;

    localparam pos_t XMIN_S   = pos_t'(X_MIN);
    localparam pos_t YMIN_S   = pos_t'(Y_MIN);
    localparam pos_t XR_S     = pos_t'(XR);
    localparam pos_t GROUND_S = pos_t'(GROUND_Y);
    localparam pos_t WALK_S   = pos_t'(WALK_STEP);
    localparam pos_t JUMP_S   = pos_t'(JUMP_VEL);
    localparam pos_t GRAV_S   = pos_t'(GRAVITY);
    localparam pos_t MAXF_S   = pos_t'(MAX_FALL);

    logic tick;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [4:0]    vy_q, vy_d;
    player_state_t state_q, state_d;
    logic          facing_q, facing_d;
    logic          w_prev_q, w_prev_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic          air_q, air_d;
`endif

    logic key_a, key_d, key_w;
    pos_t x_cur, y_cur, vy_cur, x_n, y_n, vy_n;

    assign key_a  = key_pressed(keycode, KEY_A);
    assign key_d  = key_pressed(keycode, KEY_D);
    assign key_w  = key_pressed(keycode, KEY_W);
    assign x_cur  = $signed({1'b0, x_q});
    assign y_cur  = $signed({1'b0, y_q});
    assign vy_cur = $signed({6'b0, vy_q});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q      <= 10'(X_START);
            y_q      <= 10'(GROUND_Y);
            vy_q     <= '0;
            state_q  <= GROUND;
            facing_q <= 1'b0;
            w_prev_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_q    <= 1'b0;
`endif
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            state_q  <= state_d;
            facing_q <= facing_d;
            w_prev_q <= w_prev_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_q    <= air_d;
`endif
        end
    end

    always_comb begin
        x_n      = x_cur;
        y_n      = y_cur;
        vy_n     = vy_cur;
        state_d  = state_q;
        facing_d = facing_q;
        w_prev_d = w_prev_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
        air_d    = air_q;
`endif
        if (tick) begin
            w_prev_d = key_w;

            if (key_a && !key_d) begin
                x_n      = x_cur - WALK_S;
                facing_d = 1'b1;
                if (x_n < XMIN_S) x_n = XMIN_S;
            end else if (key_d && !key_a) begin
                x_n      = x_cur + WALK_S;
                facing_d = 1'b0;
                if (x_n > XR_S) x_n = XR_S;
            end

            unique case (state_q)
                GROUND: begin
                    if (key_w) begin
                        y_n     = y_cur - JUMP_S;
                        vy_n    = JUMP_S - GRAV_S;
                        state_d = RISE;
                        if (y_n < YMIN_S) begin
                            y_n     = YMIN_S;
                            vy_n    = '0;
                            state_d = FALL;
                        end
                    end
                end
                RISE: begin
                    if (y_cur - vy_cur < YMIN_S) begin
                        y_n     = YMIN_S;
                        vy_n    = '0;
                        state_d = FALL;
                    end else begin
                        y_n  = y_cur - vy_cur;
                        vy_n = vy_cur - GRAV_S;
                        if (vy_n == '0) state_d = FALL;
                    end
                end
                FALL: begin
                    vy_n = vy_cur + GRAV_S;
                    if (vy_n > MAXF_S) vy_n = MAXF_S;
                    y_n = y_cur + vy_n;
                    if (y_n >= GROUND_S) begin
                        y_n     = GROUND_S;
                        vy_n    = '0;
                        state_d = GROUND;
                    end
                end
                default: state_d = GROUND;
            endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
            // Air jump overrides the normal airborne update, including a landing on this tick.
            if (state_q != GROUND && key_w && !w_prev_q && !air_q) begin
                y_n     = y_cur - JUMP_S;
                vy_n    = JUMP_S - GRAV_S;
                state_d = RISE;
                air_d   = 1'b1;
                if (y_n < YMIN_S) begin
                    y_n     = YMIN_S;
                    vy_n    = '0;
                    state_d = FALL;
                end
            end
            if (state_d == GROUND) air_d = 1'b0;
`endif
        end

        x_d  = x_n[9:0];
        y_d  = y_n[9:0];
        vy_d = vy_n[4:0];
    end

    logic unused_bits;
    assign unused_bits = ^{x_n[10], y_n[10], vy_n[10:5]};

    localparam logic [10:0] PW11 = 11'(P_W);
    localparam logic [10:0] PH11 = 11'(P_H);
    localparam logic [12:0] PW13 = 13'(P_W);

    logic [10:0] dx, dy;
    logic        in_x, in_y;

    assign dx   = {1'b0, DrawX} - {1'b0, x_q};
    assign dy   = {1'b0, DrawY} - {1'b0, y_q};
    assign in_x = (DrawX >= x_q) && (dx < PW11);
    assign in_y = (DrawY >= y_q) && (dy < PH11);

    assign is_player1 = in_x & in_y;
    assign spr_addr   = is_player1 ? (13'(dy) * PW13 + 13'(dx)) : '0;

    assign p1x      = x_q;
    assign p1y      = y_q;
    assign p1_w     = 10'(P_W);
    assign p1_h     = 10'(P_H);
    assign p1_state = state_q;
    assign facing   = facing_q;

endmodule

// File: tb/tb_player1_controller.sv
// Randomized self-checking bench for player1_controller against an integer
// reference model of the walk/jump/gravity rules and the sprite hit box.
module tb_player1_controller;

    localparam int XR_M    = 608;
    localparam int GND_M   = 416;
    localparam int WALK_M  = 2;
    localparam int JUMP_M  = 12;
    localparam int MAXF_M  = 12;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [15:0] keycode = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        is_player1;
    logic [9:0]  p1x, p1y, p1_w, p1_h;
    logic [12:0] spr_addr;
    logic [1:0]  p1_state;
    logic        facing;

    player1_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .is_player1 (is_player1),
        .p1x        (p1x),
        .p1y        (p1y),
        .p1_w       (p1_w),
        .p1_h       (p1_h),
        .spr_addr   (spr_addr),
        .p1_state   (p1_state),
        .facing     (facing)
    );

    always #5 Clk = ~Clk;

    int npass  = 0;
    int ntotal = 0;

    // Reference model state (plain integers, state 0/1/2 = ground/rise/fall)
    int mx, my, mvy, mst, mfac, mwp, mair;

    task automatic model_reset();
        mx = 100; my = GND_M; mvy = 0; mst = 0; mfac = 0; mwp = 0; mair = 0;
    endtask

    task automatic model_tick(input logic [15:0] kc);
        bit a, d, w;
        int old_st;
        a = (kc[7:0] == 8'h04) || (kc[15:8] == 8'h04);
        d = (kc[7:0] == 8'h07) || (kc[15:8] == 8'h07);
        w = (kc[7:0] == 8'h1A) || (kc[15:8] == 8'h1A);
        old_st = mst;
        if (a && !d) begin
            mx = (mx - WALK_M < 0) ? 0 : mx - WALK_M;
            mfac = 1;
        end else if (d && !a) begin
            mx = (mx + WALK_M > XR_M) ? XR_M : mx + WALK_M;
            mfac = 0;
        end
        if (mst == 0) begin
            if (w) begin
                my = my - JUMP_M; mvy = JUMP_M - 1; mst = 1;
                if (my < 0) begin my = 0; mvy = 0; mst = 2; end
            end
        end else if (mst == 1) begin
            if (my - mvy < 0) begin
                my = 0; mvy = 0; mst = 2;
            end else begin
                my = my - mvy; mvy = mvy - 1;
                if (mvy == 0) mst = 2;
            end
        end else begin
            mvy = (mvy + 1 > MAXF_M) ? MAXF_M : mvy + 1;
            my = my + mvy;
            if (my >= GND_M) begin my = GND_M; mvy = 0; mst = 0; end
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
        if (old_st != 0 && w && !mwp && !mair) begin
            my = my_before_air(my, mvy, old_st);
            mst = 1; mvy = JUMP_M - 1; mair = 1;
            if (my < 0) begin my = 0; mvy = 0; mst = 2; end
        end
        if (mst == 0) mair = 0;
`endif
        mwp = w;
    endtask

    // Position before this tick's airborne update, from which an air jump starts.
    int y_pre;
    function automatic int my_before_air(input int ynow, input int vnow, input int st);
        return y_pre - JUMP_M;
    endfunction

    task automatic do_tick(input logic [15:0] kc);
        @(negedge Clk);
        keycode   = kc;
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        y_pre = my;
        model_tick(kc);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        keycode = '0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1; frame_clk = 1'b1; keycode = 16'h1A07;
        repeat (2) @(negedge Clk);
        ntotal++;
        if ({p1x, p1y, p1_state, facing} !== {10'd100, 10'd416, 2'd0, 1'b0}) begin
            $display("FAIL reset_state: got x=%0d y=%0d st=%0d f=%0d want x=100 y=416 st=0 f=0",
                     p1x, p1y, p1_state, facing);
        end else npass++;
        ntotal++;
        if ({p1_w, p1_h} !== {10'd32, 10'd64}) begin
            $display("FAIL box_size: got w=%0d h=%0d want w=32 h=64", p1_w, p1_h);
        end else npass++;
        frame_clk = 1'b0; Reset = 1'b0; keycode = '0;
        model_reset();
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_tick_latency();
        do_reset();
        keycode = 16'h0007;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        ntotal++;
        if (p1x !== 10'd100) $display("FAIL latency_early: got x=%0d want 100", p1x);
        else npass++;
        @(negedge Clk);
        ntotal++;
        if (p1x !== 10'd102) $display("FAIL latency_edge: got x=%0d want 102", p1x);
        else npass++;
        repeat (8) @(negedge Clk);
        ntotal++;
        if (p1x !== 10'd102) $display("FAIL single_tick: got x=%0d want 102", p1x);
        else npass++;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        y_pre = my;
        model_tick(16'h0007);
    endtask

    task automatic test_jump();
        do_reset();
        do_tick(16'h001A);
        ntotal++;
        if ({p1y, p1_state} !== {10'd404, 2'd1}) $display("FAIL jump_t1: got y=%0d st=%0d want y=404 st=1", p1y, p1_state);
        else npass++;
        for (int i = 2; i <= 24; i++) begin
            do_tick(16'h0000);
            ntotal++;
            if ({p1x, p1y, p1_state, facing} !== {10'(mx), 10'(my), 2'(mst), 1'(mfac)})
                $display("FAIL jump_t%0d: got y=%0d st=%0d want y=%0d st=%0d", i, p1y, p1_state, my, mst);
            else npass++;
            if (i == 12) begin
                ntotal++;
                if ({p1y, p1_state} !== {10'd338, 2'd2}) $display("FAIL jump_apex: got y=%0d st=%0d want y=338 st=2", p1y, p1_state);
                else npass++;
            end
        end
        ntotal++;
        if ({p1y, p1_state} !== {10'd416, 2'd0}) $display("FAIL jump_land: got y=%0d st=%0d want y=416 st=0", p1y, p1_state);
        else npass++;
    endtask

    task automatic test_clamps();
        do_reset();
        repeat (253) do_tick(16'h0007);
        ntotal++;
        if (p1x !== 10'd606) $display("FAIL walk_to_606: got x=%0d want 606", p1x);
        else npass++;
        do_tick(16'h0007);
        ntotal++;
        if (p1x !== 10'd608) $display("FAIL right_clamp1: got x=%0d want 608", p1x);
        else npass++;
        do_tick(16'h0700);
        ntotal++;
        if (p1x !== 10'd608) $display("FAIL right_clamp2: got x=%0d want 608", p1x);
        else npass++;
        do_tick(16'h0704);
        ntotal++;
        if ({p1x, facing} !== {10'd608, 1'b0}) $display("FAIL a_and_d: got x=%0d f=%0d want x=608 f=0", p1x, facing);
        else npass++;
        do_tick(16'h0400);
        ntotal++;
        if ({p1x, facing} !== {10'd606, 1'b1}) $display("FAIL walk_left: got x=%0d f=%0d want x=606 f=1", p1x, facing);
        else npass++;
        do_reset();
        repeat (51) do_tick(16'h0004);
        ntotal++;
        if ({p1x, facing} !== {10'd0, 1'b1}) $display("FAIL left_clamp: got x=%0d f=%0d want x=0 f=1", p1x, facing);
        else npass++;
    endtask

    task automatic test_hit();
        int px, py, ein, eaddr;
        do_reset();
        @(negedge Clk);
        DrawX = 10'd100; DrawY = 10'd416; #1;
        ntotal++;
        if ({is_player1, spr_addr} !== {1'b1, 13'd0}) $display("FAIL hit_corner: got in=%0d addr=%0d want in=1 addr=0", is_player1, spr_addr);
        else npass++;
        DrawX = 10'd131; DrawY = 10'd479; #1;
        ntotal++;
        if ({is_player1, spr_addr} !== {1'b1, 13'd2047}) $display("FAIL hit_last: got in=%0d addr=%0d want in=1 addr=2047", is_player1, spr_addr);
        else npass++;
        DrawX = 10'd132; #1;
        ntotal++;
        if ({is_player1, spr_addr} !== {1'b0, 13'd0}) $display("FAIL hit_outside: got in=%0d addr=%0d want in=0 addr=0", is_player1, spr_addr);
        else npass++;
        for (int i = 0; i < 40; i++) begin
            px = 96 + $urandom_range(0, 40);
            py = 410 + $urandom_range(0, 69);
            DrawX = 10'(px); DrawY = 10'(py); #1;
            ein = (px >= mx && px < mx + 32 && py >= my && py < my + 64) ? 1 : 0;
            eaddr = ein ? (py - my) * 32 + (px - mx) : 0;
            ntotal++;
            if ({is_player1, spr_addr} !== {1'(ein), 13'(eaddr)})
                $display("FAIL hit_rand(%0d,%0d): got in=%0d addr=%0d want in=%0d addr=%0d", px, py, is_player1, spr_addr, ein, eaddr);
            else npass++;
        end
    endtask

    task automatic test_reset_midjump();
        do_reset();
        do_tick(16'h001A);
        repeat (3) do_tick(16'h0000);
        ntotal++;
        if ({p1y, p1_state} !== {10'(my), 2'(mst)}) $display("FAIL midjump_t4: got y=%0d st=%0d want y=%0d st=%0d", p1y, p1_state, my, mst);
        else npass++;
        @(negedge Clk);
        keycode = 16'h0004;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        ntotal++;
        if ({p1x, p1y, p1_state} !== {10'd100, 10'd416, 2'd0}) $display("FAIL midjump_reset: got x=%0d y=%0d st=%0d want x=100 y=416 st=0", p1x, p1y, p1_state);
        else npass++;
        Reset = 1'b0; frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        ntotal++;
        if ({p1x, p1y, p1_state} !== {10'd100, 10'd416, 2'd0}) $display("FAIL midjump_after: got x=%0d y=%0d st=%0d want x=100 y=416 st=0", p1x, p1y, p1_state);
        else npass++;
        keycode = '0;
        model_reset();
    endtask

    task automatic test_double_jump();
        do_reset();
        do_tick(16'h001A);
        repeat (11) do_tick(16'h0000);
        do_tick(16'h001A);
        ntotal++;
`ifdef PLAYER_DOUBLE_JUMP_EN
        if ({p1y, p1_state} !== {10'd326, 2'd1}) $display("FAIL air_jump: got y=%0d st=%0d want y=326 st=1", p1y, p1_state);
`else
        if ({p1y, p1_state} !== {10'd339, 2'd2}) $display("FAIL air_jump: got y=%0d st=%0d want y=339 st=2", p1y, p1_state);
`endif
        else npass++;
        do_tick(16'h0000);
        do_tick(16'h1A00);
        ntotal++;
`ifdef PLAYER_DOUBLE_JUMP_EN
        if ({p1y, p1_state} !== {10'd305, 2'd1}) $display("FAIL third_press: got y=%0d st=%0d want y=305 st=1", p1y, p1_state);
`else
        if ({p1y, p1_state} !== {10'd344, 2'd2}) $display("FAIL third_press: got y=%0d st=%0d want y=344 st=2", p1y, p1_state);
`endif
        else npass++;
        ntotal++;
        if ({p1y, p1_state} !== {10'(my), 2'(mst)}) $display("FAIL dj_model: got y=%0d st=%0d want y=%0d st=%0d", p1y, p1_state, my, mst);
        else npass++;
    endtask

    task automatic test_random();
        logic [15:0] pool [10];
        logic [15:0] kc;
        int px, py, ein, eaddr;
        pool = '{16'h0000, 16'h0004, 16'h0007, 16'h001A, 16'h0704,
                 16'h1A04, 16'h071A, 16'h1A00, 16'h0400, 16'h0000};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            kc = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) kc = 16'($urandom);
            do_tick(kc);
            ntotal++;
            if ({p1x, p1y, p1_state, facing} !== {10'(mx), 10'(my), 2'(mst), 1'(mfac)})
                $display("FAIL rand_tick%0d kc=%h: got x=%0d y=%0d st=%0d f=%0d want x=%0d y=%0d st=%0d f=%0d",
                         i, kc, p1x, p1y, p1_state, facing, mx, my, mst, mfac);
            else npass++;
            px = mx - 3 + $urandom_range(0, 38);
            py = my - 3 + $urandom_range(0, 70);
            if (px < 0) px = 0;
            if (px > 639) px = 639;
            if (py < 0) py = 0;
            if (py > 479) py = 479;
            DrawX = 10'(px); DrawY = 10'(py); #1;
            ein = (px >= mx && px < mx + 32 && py >= my && py < my + 64) ? 1 : 0;
            eaddr = ein ? (py - my) * 32 + (px - mx) : 0;
            ntotal++;
            if ({is_player1, spr_addr} !== {1'(ein), 13'(eaddr)})
                $display("FAIL rand_hit%0d(%0d,%0d): got in=%0d addr=%0d want in=%0d addr=%0d", i, px, py, is_player1, spr_addr, ein, eaddr);
            else npass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_tick_latency();
        test_jump();
        test_clamps();
        test_hit();
        test_reset_midjump();
        test_double_jump();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
